// File: rtl/tdm_demux_4ch.sv
// ============================================================================
// tdm_demux_4ch
// ----------------------------------------------------------------------------
// Time-division demultiplexer. It recovers four W-bit channel words from a
// single serial TDM stream that carries a frame sync. A frame is four slots of
// W bits, slot 0 first, with each slot sent MSB first. Only cycles with
// i_din_valid high count as beats; all other cycles leave the state untouched.
//
// Ports
//   i_clk         rising-edge clock
//   i_rst         asynchronous, active-high reset
//   i_din         serial data bit, MSB of each slot first
//   i_din_valid   qualifies i_din and i_fsync; nothing is sampled when low
//   i_fsync       frame sync, high together with bit 0 of slot 0
//   o_y           channel words, slot k in o_y[k*W +: W]
//   o_ch_valid    one-cycle pulse per channel when its o_y slice is written
//   o_frame_done  one-cycle pulse together with o_ch_valid[3]
//   o_sync_err    one-cycle pulse on a framing violation
//   o_locked      high while the receiver is aligned to the frame (RECV)
// ============================================================================
module tdm_demux_4ch #(
    parameter int W = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_din,
    input  logic           i_din_valid,
    input  logic           i_fsync,
    output logic [4*W-1:0] o_y,
    output logic [3:0]     o_ch_valid,
    output logic           o_frame_done,
    output logic           o_sync_err,
    output logic           o_locked
);

    localparam int BW = $clog2(W);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    typedef enum logic {
        HUNT,
        RECV
    } state_t;

    state_t         r_state;
    logic [BW-1:0]  r_bcnt;
    logic [1:0]     r_scnt;
    logic [W-1:0]   r_sr;
    logic [4*W-1:0] r_y;
    logic [3:0]     r_chValid;
    logic           r_frameDone;
    logic           r_syncErr;

    state_t         w_stateNext;
    logic [BW-1:0]  w_bcntNext;
    logic [1:0]     w_scntNext;
    logic [W-1:0]   w_srNext;
    logic [4*W-1:0] w_yNext;
    logic [3:0]     w_chValidNext;
    logic           w_frameDoneNext;
    logic           w_syncErrNext;
    logic [W-1:0]   w_word;
    logic           w_frameStart;

    // State and data registers. Every output comes straight from a register,
    // so a completed slot is visible on the same edge that samples its last
    // bit. The pulse registers are rewritten every cycle, which keeps each
    // pulse exactly one cycle long even when the next cycle is a stall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= HUNT;
            r_bcnt      <= '0;
            r_scnt      <= '0;
            r_sr        <= '0;
            r_y         <= '0;
            r_chValid   <= '0;
            r_frameDone <= 1'b0;
            r_syncErr   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_bcnt      <= w_bcntNext;
            r_scnt      <= w_scntNext;
            r_sr        <= w_srNext;
            r_y         <= w_yNext;
            r_chValid   <= w_chValidNext;
            r_frameDone <= w_frameDoneNext;
            r_syncErr   <= w_syncErrNext;
        end
    end

    // Next-state and next-output logic. An fsync that arrives anywhere other
    // than the expected frame start restarts the frame at this beat. The
    // interrupted slot is dropped: it never reached its last bit, so it never
    // wrote o_y. A missing fsync at the frame start drops the lock and sends
    // the receiver back to HUNT.
    always_comb begin
        w_stateNext     = r_state;
        w_bcntNext      = r_bcnt;
        w_scntNext      = r_scnt;
        w_srNext        = r_sr;
        w_yNext         = r_y;
        w_chValidNext   = '0;
        w_frameDoneNext = 1'b0;
        w_syncErrNext   = 1'b0;
        w_word          = {r_sr[W-2:0], i_din};
        w_frameStart    = (r_bcnt == '0) && (r_scnt == 2'd0);

        if (i_din_valid) begin
            case (r_state)
                HUNT: begin
                    if (i_fsync) begin
                        w_srNext    = w_word;
                        w_bcntNext  = BW'(1);
                        w_scntNext  = 2'd0;
                        w_stateNext = RECV;
                    end
                end
                RECV: begin
                    if (i_fsync) begin
                        w_syncErrNext = !w_frameStart;
                        w_srNext      = w_word;
                        w_bcntNext    = BW'(1);
                        w_scntNext    = 2'd0;
                    end else if (w_frameStart) begin
                        w_syncErrNext = 1'b1;
                        w_bcntNext    = '0;
                        w_scntNext    = 2'd0;
                        w_stateNext   = HUNT;
                    end else begin
                        w_srNext = w_word;
                        if (r_bcnt == LAST_BIT) begin
                            for (int k = 0; k < 4; k++) begin
                                if (r_scnt == 2'(k)) begin
                                    w_yNext[k*W +: W] = w_word;
                                end
                            end
                            w_chValidNext[r_scnt] = 1'b1;
                            w_frameDoneNext       = (r_scnt == 2'd3);
                            w_bcntNext            = '0;
                            w_scntNext            = r_scnt + 2'd1;
                        end else begin
                            w_bcntNext = r_bcnt + BW'(1);
                        end
                    end
                end
                default: begin
                    w_stateNext = HUNT;
                end
            endcase
        end
    end

    assign o_y          = r_y;
    assign o_ch_valid   = r_chValid;
    assign o_frame_done = r_frameDone;
    assign o_sync_err   = r_syncErr;
    assign o_locked     = (r_state == RECV);

endmodule
